// File: rtl/dmem_pkg.sv
// Shared definitions for data_memory_unit: access-size encoding, FSM states,
// and size-to-bytecount / lane-mask helpers.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'b00,
        SZ_HALF  = 2'b01,
        SZ_WORD  = 2'b10,
        SZ_DWORD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        BEAT2 = 2'b01,
        RESP  = 2'b10
    } state_e;

    localparam int LANES = 8;

    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_BYTE:  return 4'd1;
            SZ_HALF:  return 4'd2;
            SZ_WORD:  return 4'd4;
            SZ_DWORD: return 4'd8;
            default:  return 4'd8;
        endcase
    endfunction

    // Right-justified lane mask: one bit per byte moved by an access of this size
    function automatic logic [LANES-1:0] lane_mask(input logic [1:0] size);
        case (size)
            SZ_BYTE:  return 8'h01;
            SZ_HALF:  return 8'h03;
            SZ_WORD:  return 8'h0F;
            SZ_DWORD: return 8'hFF;
            default:  return 8'hFF;
        endcase
    endfunction

    function automatic logic [63:0] data_mask(input logic [1:0] size);
        case (size)
            SZ_BYTE:  return 64'h0000_0000_0000_00FF;
            SZ_HALF:  return 64'h0000_0000_0000_FFFF;
            SZ_WORD:  return 64'h0000_0000_FFFF_FFFF;
            SZ_DWORD: return 64'hFFFF_FFFF_FFFF_FFFF;
            default:  return 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// Eight-lane synchronous RAM: per-lane write enables, registered read port.
// Lane 7 (bits 63:56) holds the lowest byte address of a row.
module dmem_bank #(
    parameter int ROWS  = 128,
    parameter int ROW_W = 7
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic [7:0]       i_we,
    input  logic [ROW_W-1:0] i_row,
    input  logic [63:0]      i_wdata,
    output logic [63:0]      o_rdata
);

    logic [63:0] r_mem [ROWS];
    logic [63:0] r_rdata;

    // Lane-enabled write; contents are deliberately left out of reset
    always_ff @(posedge i_clk) begin
        for (int l = 0; l < 8; l++) begin
            if (i_we[l]) begin
                r_mem[i_row][8*l +: 8] <= i_wdata[8*l +: 8];
            end
        end
    end

    // Registered read, held while the port is idle so responses stay stable
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata <= 64'd0;
        end else if (i_en) begin
            r_rdata <= r_mem[i_row];
        end else begin
            r_rdata <= r_rdata;
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/data_memory_unit.sv
// Big-endian byte-addressable data memory with one outstanding request.
// Define DMEM_MISALIGN_EN to serve row-crossing accesses in two beats.
module data_memory_unit
    import dmem_pkg::*;
#(
    parameter int DEPTH_BYTES = 1024,
    parameter int ADDR_W      = 64
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              ReqValid,
    output logic              ReqReady,
    input  logic              ReqWrite,
    input  logic [1:0]        ReqSize,
    input  logic              ReqSigned,
    input  logic [ADDR_W-1:0] ReqAddr,
    input  logic [63:0]       ReqWData,
    output logic              RespValid,
    input  logic              RespReady,
    output logic [63:0]       RespRData,
    output logic              RespErr
);

    localparam int ROWS  = DEPTH_BYTES / 8;
    localparam int ROW_W = $clog2(ROWS);

    state_e           r_state;
    logic             r_req_ready;
    logic             r_resp_valid;
    logic             r_resp_err;
    logic             r_write;
    logic             r_signed;
    logic             r_split;
    logic [1:0]       r_size;
    logic [2:0]       r_off;
    logic [ROW_W-1:0] r_row;
    logic [63:0]      r_wdata1;
    logic [7:0]       r_we1;
    logic [63:0]      r_row0;

    logic [3:0]       w_nbytes;
    logic [2:0]       w_off;
    logic             w_range_err;
    logic             w_mis_err;
    logic             w_err;
    logic             w_split;
    logic [4:0]       w_shift16;
    logic [127:0]     w_wwin;
    logic [15:0]      w_wmask16;
    logic             w_accept;

    logic             w_bank_en;
    logic [7:0]       w_bank_we;
    logic [ROW_W-1:0] w_bank_row;
    logic [63:0]      w_bank_wdata;
    logic [63:0]      w_bank_rdata;

    logic [3:0]       w_rbytes;
    logic [4:0]       w_rshift16;
    logic [127:0]     w_rwin;
    logic [63:0]      w_rraw;
    logic [5:0]       w_sign_idx;
    logic             w_sign;
    logic [63:0]      w_rext;

    assign w_nbytes  = size_bytes(ReqSize);
    assign w_off     = ReqAddr[2:0];
    // Computed one bit wider than the address so a near-max address cannot wrap into range
    assign w_range_err = ({1'b0, ReqAddr} + {{(ADDR_W-3){1'b0}}, w_nbytes})
                         > (ADDR_W+1)'(DEPTH_BYTES);
`ifdef DMEM_MISALIGN_EN
    assign w_mis_err = 1'b0;
    assign w_split   = (({1'b0, w_off} + w_nbytes) > 4'd8) && !w_range_err;
`else
    assign w_mis_err = |(w_off & (w_nbytes[2:0] - 3'd1));
    assign w_split   = 1'b0;
`endif
    assign w_err     = w_range_err || w_mis_err;
    assign w_accept  = ReqValid && r_req_ready;

    // Access bytes sit at positions off..off+n-1 of a two-row, 16-byte window
    assign w_shift16 = 5'd16 - {2'b00, w_off} - {1'b0, w_nbytes};
    assign w_wwin    = {64'd0, ReqWData & data_mask(ReqSize)} << {w_shift16, 3'b000};
    assign w_wmask16 = {8'd0, lane_mask(ReqSize)} << w_shift16;

    // Bank port steering: first row on accept, second row during BEAT2
    always_comb begin
        w_bank_en    = 1'b0;
        w_bank_we    = 8'd0;
        w_bank_row   = ReqAddr[ROW_W+2:3];
        w_bank_wdata = w_wwin[127:64];
        if (r_state == BEAT2) begin
            w_bank_en    = 1'b1;
            w_bank_we    = r_we1;
            w_bank_row   = r_row + ROW_W'(1);
            w_bank_wdata = r_wdata1;
        end else if (w_accept && !w_err) begin
            w_bank_en    = 1'b1;
            w_bank_we    = ReqWrite ? w_wmask16[15:8] : 8'd0;
        end else begin
            w_bank_en    = 1'b0;
        end
    end

    dmem_bank #(
        .ROWS  (ROWS),
        .ROW_W (ROW_W)
    ) u_bank (
        .i_clk   (Clk),
        .i_rst_n (Reset_n),
        .i_en    (w_bank_en),
        .i_we    (w_bank_we),
        .i_row   (w_bank_row),
        .i_wdata (w_bank_wdata),
        .o_rdata (w_bank_rdata)
    );

    // Request/response sequencing FSM
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state      <= IDLE;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_write      <= 1'b0;
            r_signed     <= 1'b0;
            r_split      <= 1'b0;
            r_size       <= 2'b00;
            r_off        <= 3'd0;
            r_row        <= '0;
            r_wdata1     <= 64'd0;
            r_we1        <= 8'd0;
            r_row0       <= 64'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (ReqValid) begin
                        r_write     <= ReqWrite;
                        r_signed    <= ReqSigned;
                        r_size      <= ReqSize;
                        r_off       <= w_off;
                        r_row       <= ReqAddr[ROW_W+2:3];
                        r_wdata1    <= w_wwin[63:0];
                        r_we1       <= ReqWrite ? w_wmask16[7:0] : 8'd0;
                        r_resp_err  <= w_err;
                        r_split     <= w_split;
                        r_req_ready <= 1'b0;
                        if (w_split) begin
                            r_state <= BEAT2;
                        end else begin
                            r_state      <= RESP;
                            r_resp_valid <= 1'b1;
                        end
                    end
                end
                BEAT2: begin
                    r_row0       <= w_bank_rdata;
                    r_state      <= RESP;
                    r_resp_valid <= 1'b1;
                end
                RESP: begin
                    if (RespReady) begin
                        r_state      <= IDLE;
                        r_resp_valid <= 1'b0;
                        r_resp_err   <= 1'b0;
                        r_req_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_resp_valid <= 1'b0;
                    r_resp_err   <= 1'b0;
                    r_req_ready  <= 1'b1;
                end
            endcase
        end
    end

    // Load result: realign the window, then zero- or sign-extend
    assign w_rbytes   = size_bytes(r_size);
    assign w_rshift16 = 5'd16 - {2'b00, r_off} - {1'b0, w_rbytes};
    assign w_rwin     = r_split ? {r_row0, w_bank_rdata} : {w_bank_rdata, 64'd0};
    assign w_rraw     = 64'(w_rwin >> {w_rshift16, 3'b000}) & data_mask(r_size);
    assign w_sign_idx = 6'({w_rbytes, 3'b000} - 7'd1);
    assign w_sign     = r_signed && (r_size != SZ_DWORD) && w_rraw[w_sign_idx];
    assign w_rext     = w_sign ? (w_rraw | ~data_mask(r_size)) : w_rraw;

    assign ReqReady  = r_req_ready;
    assign RespValid = r_resp_valid;
    assign RespErr   = r_resp_err;
    assign RespRData = (r_resp_valid && !r_write && !r_resp_err) ? w_rext : 64'd0;

endmodule

// File: doc/data_memory_unit.md
DATA_MEMORY_UNIT -- requirements
Module: data_memory_unit

Interface
REQ-001 SHALL have parameter DEPTH_BYTES, default 1024, total byte capacity; power of two, at least 16.
REQ-002 SHALL have parameter ADDR_W, default 64, request address width.
REQ-003 SHALL have port Clk, input, 1, sole clock; all state updates on posedge.
REQ-004 SHALL have port Reset_n, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port ReqValid, input, 1, request offered.
REQ-006 SHALL have port ReqReady, output, 1, request accepted when ReqValid&&ReqReady at posedge.
REQ-007 SHALL have port ReqWrite, input, 1, 1=store, 0=load.
REQ-008 SHALL have port ReqSize, input, 2, 00 byte, 01 half, 10 word, 11 dword.
REQ-009 SHALL have port ReqSigned, input, 1, load sign-extension enable.
REQ-010 SHALL have port ReqAddr, input, ADDR_W, byte address.
REQ-011 SHALL have port ReqWData, input, 64, store data, right-justified.
REQ-012 SHALL have port RespValid, output, 1, response present.
REQ-013 SHALL have port RespReady, input, 1, response consumed when RespValid&&RespReady at posedge.
REQ-014 SHALL have port RespRData, output, 64, load result, right-justified.
REQ-015 SHALL have port RespErr, output, 1, access out of range or (macro off) misaligned.

Function
REQ-016 Storage SHALL be DEPTH_BYTES/8 rows of 8 byte lanes; byte order big-endian (lowest address holds most significant byte).
REQ-017 FSM states SHALL be IDLE, BEAT2, RESP; ReqReady=1 only in IDLE.
REQ-018 Aligned access (within one 8-byte row) accepted at edge N: read/write at edge N, state->RESP, RespValid=1 from cycle N+1.
REQ-019 Row-crossing access: first row at edge N, IDLE->BEAT2, second row at edge N+1, BEAT2->RESP, RespValid=1 from N+2.
REQ-020 RESP SHALL hold RespValid, RespRData, RespErr stable until RespReady; then ->IDLE; RespReady in other states ignored.
REQ-021 Store SHALL write only the size bytes from ReqWData low bits via lane enables; other bytes unchanged; store response RespRData=0.
REQ-022 Load SHALL zero-extend, or sign-extend from the top loaded byte when ReqSigned=1; ReqSigned ignored for dword.
REQ-023 ReqAddr+size > DEPTH_BYTES (ADDR_W arithmetic, no wrap) SHALL give RespErr=1, RespRData=0, no write, aligned latency.
REQ-024 Address wrap-around at DEPTH_BYTES SHALL never occur; last legal dword at DEPTH_BYTES-8.

Reset
REQ-025 Reset_n low SHALL force IDLE, ReqReady=1 after release, RespValid=0, RespRData=0, RespErr=0.
REQ-026 Reset in BEAT2 SHALL abort; first-row bytes of a split store MAY remain written; no response produced.
REQ-027 Memory contents SHALL NOT be reset.

Configuration
REQ-028 Macro DMEM_MISALIGN_EN defined: row-crossing accesses SHALL use two-beat path of REQ-019.
REQ-029 Macro undefined: any access not aligned to its size SHALL give RespErr=1, no write, aligned latency; BEAT2 absent.

Structure
REQ-030 Package dmem_pkg SHALL hold size encoding, FSM state type, size-to-bytecount and lane-mask constants.
REQ-031 Sub-module dmem_bank SHALL implement the 8-lane synchronous RAM with per-lane write enables and registered read.

Verification
REQ-032 Store dword 0x0FFBEA7DEADBEEFF @0x18, load dword @0x18 -> RespRData=0x0FFBEA7DEADBEEFF, RespErr=0, RespValid one cycle after accept.
REQ-033 Store byte 0x80 @0x21, load byte signed @0x21 -> 0xFFFFFFFFFFFFFF80; unsigned -> 0x80; load dword @0x20 -> 0x0080000000000000 (from zeroed row).
REQ-034 Macro on: store word 0x11223344 @0x26, load word @0x26 -> 0x11223344, RespValid two cycles after accept; macro off -> RespErr=1, memory unchanged.
REQ-035 Load dword @DEPTH_BYTES-4 -> RespErr=1, RespRData=0; store there -> no bytes modified.
REQ-036 Hold RespReady=0 for 5 cycles -> RespValid, RespRData stable, ReqReady=0; assert Reset_n=0 during BEAT2 -> RespValid=0, IDLE, next request served normally.
